// File: rtl/lc2k_alu_stage.sv
// LC2K execute stage: ALU (add/nor/sub-compare/pass) feeding a registered output
// backed by a one-entry skid buffer, plus a count of results handed downstream.
module lc2k_alu_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        inValid,
    output logic        inReady,
    input  logic [31:0] aluValA,
    input  logic [31:0] aluValB,
    input  logic [1:0]  aluOp,
    input  logic [2:0]  inDest,
    output logic        outValid,
    input  logic        outReady,
    output logic [31:0] aluResult,
    output logic        aluEqual,
    output logic [2:0]  outDest,
    output logic [15:0] opCount
);

    localparam logic [1:0] OP_ADD   = 2'd0;
    localparam logic [1:0] OP_NOR   = 2'd1;
    localparam logic [1:0] OP_EQ    = 2'd2;

    logic [31:0] w_result;
    logic        w_equal;
    logic        w_accept;
    logic        w_fire;

    logic        r_out_valid;
    logic [31:0] r_out_result;
    logic        r_out_equal;
    logic [2:0]  r_out_dest;

    logic        r_skid_valid;
    logic [31:0] r_skid_result;
    logic        r_skid_equal;
    logic [2:0]  r_skid_dest;

    logic [15:0] r_op_count;

    always_comb begin
        w_result = aluValB;
        case (aluOp)
            OP_ADD:  w_result = aluValA + aluValB;
            OP_NOR:  w_result = ~(aluValA | aluValB);
            OP_EQ:   w_result = aluValA - aluValB;
            default: w_result = aluValB;
        endcase
    end

    assign w_equal  = (aluValA == aluValB);
    // inReady depends only on the skid flop, so no outReady-to-inReady path exists.
    assign w_accept = inValid && !r_skid_valid;
    assign w_fire   = r_out_valid && outReady;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid   <= 1'b0;
            r_out_result  <= '0;
            r_out_equal   <= 1'b0;
            r_out_dest    <= '0;
            r_skid_valid  <= 1'b0;
            r_skid_result <= '0;
            r_skid_equal  <= 1'b0;
            r_skid_dest   <= '0;
            r_op_count    <= '0;
        end else begin
            if (w_fire) begin
                r_op_count <= r_op_count + 16'd1;
            end

            if (flush) begin
                r_out_valid  <= 1'b0;
                r_skid_valid <= 1'b0;
            end else if (!r_out_valid || w_fire) begin
                if (r_skid_valid) begin
                    r_out_valid  <= 1'b1;
                    r_out_result <= r_skid_result;
                    r_out_equal  <= r_skid_equal;
                    r_out_dest   <= r_skid_dest;
                    r_skid_valid <= 1'b0;
                end else if (w_accept) begin
                    r_out_valid  <= 1'b1;
                    r_out_result <= w_result;
                    r_out_equal  <= w_equal;
                    r_out_dest   <= inDest;
                end else begin
                    r_out_valid  <= 1'b0;
                end
            end else if (w_accept) begin
                // OUT is stalled: park the new entry behind it.
                r_skid_valid  <= 1'b1;
                r_skid_result <= w_result;
                r_skid_equal  <= w_equal;
                r_skid_dest   <= inDest;
            end
        end
    end

    assign inReady   = !r_skid_valid;
    assign outValid  = r_out_valid;
    assign aluResult = r_out_result;
    assign aluEqual  = r_out_equal;
    assign outDest   = r_out_dest;
    assign opCount   = r_op_count;

endmodule
